// File: rtl/axi_pkg.sv
// Shared AXI channel widths, packed channel payload structs and small sizing helpers.
package axi_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } axi_aw_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } axi_ar_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_t;

  // Payload widths handed to axi_chan_fifo as DATA_WIDTH by the instantiator.
  localparam int unsigned AXI_AW_W = $bits(axi_aw_t);
  localparam int unsigned AXI_W_W  = $bits(axi_w_t);
  localparam int unsigned AXI_B_W  = $bits(axi_b_t);
  localparam int unsigned AXI_AR_W = $bits(axi_ar_t);
  localparam int unsigned AXI_R_W  = $bits(axi_r_t);

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers with explicit wrap, occupancy count and status flags for a DEPTH-entry
// circular buffer; storage lives in the instantiating module.
module fifo_ptr_ctrl
  import axi_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = DEPTH - 1,
  parameter int unsigned PTR_W     = ptr_width(DEPTH),
  parameter int unsigned LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;

  // Explicit compare so non-power-of-two depths wrap correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + LVL_W'(1);
        2'b01:   count_d = count_q - LVL_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o      = wr_ptr_q;
  assign rd_ptr_o      = rd_ptr_q;
  assign level_o       = count_q;
  assign full_o        = (count_q == LVL_W'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign almost_full_o = (count_q >= LVL_W'(AF_THRESH));

endmodule

// File: rtl/axi_chan_fifo.sv
// Single-clock FIFO for one AXI channel payload with optional fall-through bypass,
// occupancy/almost-full reporting and synchronous flush.
module axi_chan_fifo
  import axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned FALL_THROUGH = 0,
  parameter int unsigned AF_THRESH    = DEPTH - 1,
  parameter int unsigned LVL_W        = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [LVL_W-1:0]      level_o,
  output logic                  almost_full_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PtrW = ptr_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr, rd_ptr;
  logic                  full, empty;
  logic                  push, pop, bypass, wr_en, pop_stored;

  fifo_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .PTR_W     (PtrW),
    .LVL_W     (LVL_W)
  ) u_ptr_ctrl (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .push_i        (wr_en),
    .pop_i         (pop_stored),
    .wr_ptr_o      (wr_ptr),
    .rd_ptr_o      (rd_ptr),
    .level_o       (level_o),
    .full_o        (full),
    .empty_o       (empty),
    .almost_full_o (almost_full_o)
  );

  // Ready comes from registered count only: no m_ready_i -> s_ready_o path.
  assign s_ready_o = ~full & ~flush_i;
  assign push      = s_valid_i & s_ready_o;

  always_comb begin
    bypass    = 1'b0;
    m_valid_o = ~empty;
    if (FALL_THROUGH != 0) begin
      bypass    = empty & s_valid_i & ~flush_i;
      m_valid_o = (~empty | s_valid_i) & ~flush_i;
    end
    m_data_o = bypass ? s_data_i : mem_q[rd_ptr];
  end

  assign pop        = m_valid_o & m_ready_i & ~flush_i;
  // A bypassed beat consumed the same cycle never touches storage.
  assign wr_en      = push & ~(bypass & m_ready_i);
  assign pop_stored = pop & ~empty;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr] <= s_data_i;
  end

  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: tb/tb_axi_chan_fifo.sv
// Directed bench for axi_chan_fifo: vector table on a DEPTH=4 registered instance, plus
// hand-written sequences for pointer wrap (DEPTH=5), fall-through bypass and full (DEPTH=8).
module tb_axi_chan_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instance A: DEPTH=4, registered output, AF_THRESH=3.
  logic       a_sv = 0, a_mr = 0, a_fl = 0;
  logic [7:0] a_sd = 0;
  logic       a_sr, a_mv, a_af, a_full, a_empty;
  logic [7:0] a_md;
  logic [2:0] a_lvl;

  axi_chan_fifo #(.DATA_WIDTH(8), .DEPTH(4), .FALL_THROUGH(0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_fl), .s_valid_i(a_sv), .s_ready_o(a_sr),
    .s_data_i(a_sd), .m_valid_o(a_mv), .m_ready_i(a_mr), .m_data_o(a_md), .level_o(a_lvl),
    .almost_full_o(a_af), .full_o(a_full), .empty_o(a_empty)
  );

  // Instance B: DEPTH=5 (non-power-of-two), registered output.
  logic       b_sv = 0, b_mr = 0;
  logic [7:0] b_sd = 0;
  logic       b_sr, b_mv, b_af, b_full, b_empty;
  logic [7:0] b_md;
  logic [2:0] b_lvl;

  axi_chan_fifo #(.DATA_WIDTH(8), .DEPTH(5), .FALL_THROUGH(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .s_valid_i(b_sv), .s_ready_o(b_sr),
    .s_data_i(b_sd), .m_valid_o(b_mv), .m_ready_i(b_mr), .m_data_o(b_md), .level_o(b_lvl),
    .almost_full_o(b_af), .full_o(b_full), .empty_o(b_empty)
  );

  // Instance C: DEPTH=8, fall-through.
  logic       c_sv = 0, c_mr = 0, c_fl = 0;
  logic [7:0] c_sd = 0;
  logic       c_sr, c_mv, c_af, c_full, c_empty;
  logic [7:0] c_md;
  logic [3:0] c_lvl;

  axi_chan_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FALL_THROUGH(1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(c_fl), .s_valid_i(c_sv), .s_ready_o(c_sr),
    .s_data_i(c_sd), .m_valid_o(c_mv), .m_ready_i(c_mr), .m_data_o(c_md), .level_o(c_lvl),
    .almost_full_o(c_af), .full_o(c_full), .empty_o(c_empty)
  );

  // Inputs applied for one cycle; expectations are the outputs just before the next edge.
  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       fl;
    int         lvl;
    logic       mv;
    logic [7:0] md;
    logic       sr;
    logic       full;
    logic       af;
    logic       empty;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sv, input logic [7:0] sd, input logic mr,
                              input logic fl, input int lvl, input logic mv,
                              input logic [7:0] md, input logic sr, input logic full,
                              input logic af, input logic empty);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr; v.fl = fl; v.lvl = lvl; v.mv = mv; v.md = md;
    v.sr = sr; v.full = full; v.af = af; v.empty = empty;
    return v;
  endfunction

  initial begin
    byte q[$];
    int  sent, recv, cyc;
    logic push, pop;

    //                sv  sd     mr fl lvl mv md     sr full af empty
    vecs.push_back(mk(1, 8'hA1, 0, 0, 0, 0, 8'h00, 1, 0, 0, 1));
    vecs.push_back(mk(1, 8'hA2, 0, 0, 1, 1, 8'hA1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'hA3, 0, 0, 2, 1, 8'hA1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'hA4, 0, 0, 3, 1, 8'hA1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 8'hEE, 0, 0, 4, 1, 8'hA1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 4, 1, 8'hA1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 3, 1, 8'hA2, 1, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 2, 1, 8'hA3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA4, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 1));
    // Push+pop at count 1.
    vecs.push_back(mk(1, 8'hB1, 0, 0, 0, 0, 8'h00, 1, 0, 0, 1));
    vecs.push_back(mk(1, 8'hB2, 1, 0, 1, 1, 8'hB1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'hB2, 1, 0, 0, 0));
    // Flush at level 3, then no stale data afterwards.
    vecs.push_back(mk(1, 8'hC1, 0, 0, 1, 1, 8'hB2, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'hC2, 0, 0, 2, 1, 8'hB2, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'hC3, 1, 1, 3, 1, 8'hB2, 0, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 1));
    vecs.push_back(mk(1, 8'hD1, 0, 0, 0, 0, 8'h00, 1, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'hD1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hD1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      a_sv = vecs[i].sv; a_sd = vecs[i].sd; a_mr = vecs[i].mr; a_fl = vecs[i].fl;
      #1;
      chk($sformatf("A[%0d] level", i), a_lvl, vecs[i].lvl);
      chk($sformatf("A[%0d] m_valid", i), a_mv, vecs[i].mv);
      if (vecs[i].mv) chk($sformatf("A[%0d] m_data", i), a_md, vecs[i].md);
      chk($sformatf("A[%0d] s_ready", i), a_sr, vecs[i].sr);
      chk($sformatf("A[%0d] full", i), a_full, vecs[i].full);
      chk($sformatf("A[%0d] almost_full", i), a_af, vecs[i].af);
      chk($sformatf("A[%0d] empty", i), a_empty, vecs[i].empty);
    end

    // Reset for one cycle at level 2.
    @(negedge clk); a_sv = 1; a_sd = 8'hE1; a_mr = 0; a_fl = 0;
    @(negedge clk); a_sd = 8'hE2;
    @(negedge clk); a_sv = 0;
    #1 chk("A pre-reset level", a_lvl, 2);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("A post-reset level", a_lvl, 0);
    chk("A post-reset m_valid", a_mv, 0);
    chk("A post-reset s_ready", a_sr, 1);
    a_sv = 1; a_sd = 8'hF1;
    @(negedge clk); a_sv = 0;
    #1;
    chk("A post-reset push level", a_lvl, 1);
    chk("A post-reset push data", a_md, 8'hF1);

    // DEPTH=5 wrap: 12 beats with random handshakes against a queue model.
    sent = 0; recv = 0; cyc = 0;
    while (recv < 12 && cyc < 400) begin
      @(negedge clk);
      b_sv = (sent < 12) && ($urandom_range(0, 3) != 0);
      b_sd = 8'(8'h30 + sent);
      b_mr = ($urandom_range(0, 1) == 1);
      #1;
      chk("B level", b_lvl, q.size());
      chk("B s_ready", b_sr, (q.size() < 5) ? 1 : 0);
      push = b_sv & b_sr;
      pop  = b_mv & b_mr;
      if (pop) begin
        chk($sformatf("B data[%0d]", recv), b_md, q.pop_front());
        recv++;
      end
      if (push) begin
        q.push_back(b_sd);
        sent++;
      end
      cyc++;
    end
    chk("B beats received", recv, 12);
    @(negedge clk); b_sv = 0; b_mr = 0;

    // FALL_THROUGH: bypass when empty and downstream ready.
    @(negedge clk); c_sv = 1; c_sd = 8'h55; c_mr = 1;
    #1;
    chk("C bypass m_valid", c_mv, 1);
    chk("C bypass m_data", c_md, 8'h55);
    chk("C bypass level", c_lvl, 0);
    @(negedge clk); c_sv = 0; c_mr = 0;
    #1;
    chk("C after bypass level", c_lvl, 0);
    chk("C after bypass empty", c_empty, 1);
    // Not ready: beat presented combinationally and also stored.
    c_sv = 1; c_sd = 8'h66;
    #1;
    chk("C ft m_valid", c_mv, 1);
    chk("C ft m_data", c_md, 8'h66);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); c_sd = 8'(8'h67 + i);
    end
    // Full with both sides active: one pop, no push.
    @(negedge clk); c_sd = 8'h77; c_mr = 1;
    #1;
    chk("C full level", c_lvl, 8);
    chk("C full flag", c_full, 1);
    chk("C full s_ready", c_sr, 0);
    chk("C full m_data", c_md, 8'h66);
    @(negedge clk); c_mr = 0;
    #1;
    chk("C after pop level", c_lvl, 7);
    chk("C after pop s_ready", c_sr, 1);
    chk("C after pop m_data", c_md, 8'h67);
    @(negedge clk); c_sv = 0;
    #1 chk("C refill level", c_lvl, 8);
    // Flush, then flush while empty with a valid beat: no bypass.
    c_fl = 1;
    @(negedge clk); c_sv = 1; c_sd = 8'h99; c_mr = 1;
    #1;
    chk("C flush level", c_lvl, 0);
    chk("C flush m_valid", c_mv, 0);
    chk("C flush s_ready", c_sr, 0);
    @(negedge clk); c_fl = 0; c_sv = 0; c_mr = 0;
    #1;
    chk("C after flush level", c_lvl, 0);
    chk("C after flush m_valid", c_mv, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
